// File: rtl/control_unit.sv
// Multicycle datapath controller: a Moore FSM whose outputs follow the current
// state; only pc_write in BRANCH also looks at the ALU zero flag.
module control_unit (
  input  logic       clk,
  input  logic       reset_in,
  input  logic [5:0] opcode,
  input  logic [15:0] immediate,
  input  logic       overflow,
  input  logic       zero_div,
  input  logic       mult_stop,
  input  logic       div_stop,
  input  logic       div_zero,
  output logic [1:0] mux_a,
  output logic [1:0] mux_ula1,
  output logic [1:0] mux_ula2,
  output logic [1:0] mux_shift_amt,
  output logic [1:0] mux_pc,
  output logic [1:0] mux_register_wr,
  output logic [1:0] load_size,
  output logic [2:0] mux_address,
  output logic [2:0] mux_register_wd,
  output logic [2:0] ula,
  output logic [2:0] shift,
  output logic       mux_b,
  output logic       mux_shift_src,
  output logic       mux_memory_wd,
  output logic       mux_high,
  output logic       mux_low,
  output logic       mux_extend,
  output logic       store_size,
  output logic       address_rg_load,
  output logic       epc_load,
  output logic       mdr_load,
  output logic       ir_load,
  output logic       high_load,
  output logic       low_load,
  output logic       a_load,
  output logic       b_load,
  output logic       ula_out_load,
  output logic       pc_write,
  output logic       memory_wr,
  output logic       reg_wr,
  output logic       is_beq,
  output logic       is_bne,
  output logic       mult_init,
  output logic       div_init
);

  localparam logic [5:0] OP_NOP  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_LH   = 6'b100001;
  localparam logic [5:0] OP_LB   = 6'b100000;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_SB   = 6'b101000;
  localparam logic [5:0] OP_SLLM = 6'b001001;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  typedef enum logic [4:0] {
    ST_RESET, ST_FETCH1, ST_FETCH2, ST_FETCH3, ST_DECODE,
    ST_EXEC, ST_WB_ALU, ST_WB_LUI, ST_ADDR, ST_MEM1, ST_MEM2, ST_MDR,
    ST_WB_MEM, ST_SH_LD, ST_SH_DO, ST_WB_SH, ST_STORE, ST_BRANCH,
    ST_EXC_OPC, ST_EXC_OVF
  } state_t;

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;

  logic unused_inputs;
  assign unused_inputs = ^{immediate, mult_stop, div_stop, div_zero};

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state_q <= ST_RESET;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Opcode is captured on leaving DECODE so later states decode from
  // registered state alone.
  always_comb begin
    state_d         = state_q;
    op_d            = op_q;
    mux_a           = '0;
    mux_ula1        = '0;
    mux_ula2        = '0;
    mux_shift_amt   = '0;
    mux_pc          = '0;
    mux_register_wr = '0;
    load_size       = '0;
    mux_address     = '0;
    mux_register_wd = '0;
    ula             = '0;
    shift           = '0;
    mux_b           = 1'b0;
    mux_shift_src   = 1'b0;
    mux_memory_wd   = 1'b0;
    mux_high        = 1'b0;
    mux_low         = 1'b0;
    mux_extend      = 1'b0;
    store_size      = 1'b0;
    address_rg_load = 1'b0;
    epc_load        = 1'b0;
    mdr_load        = 1'b0;
    ir_load         = 1'b0;
    high_load       = 1'b0;
    low_load        = 1'b0;
    a_load          = 1'b0;
    b_load          = 1'b0;
    ula_out_load    = 1'b0;
    pc_write        = 1'b0;
    memory_wr       = 1'b0;
    reg_wr          = 1'b0;
    is_beq          = 1'b0;
    is_bne          = 1'b0;
    mult_init       = 1'b0;
    div_init        = 1'b0;

    unique case (state_q)
      ST_RESET: state_d = ST_FETCH1;
      ST_FETCH1, ST_FETCH2, ST_FETCH3: begin
        mux_address = 3'b001;
        mux_ula1    = 2'b01;
        mux_ula2    = 2'b10;
        ula         = 3'b001;
        if (state_q == ST_FETCH1) state_d = ST_FETCH2;
        else if (state_q == ST_FETCH2) state_d = ST_FETCH3;
        else begin
          ir_load  = 1'b1;
          pc_write = 1'b1;
          mux_pc   = 2'b00;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        a_load       = 1'b1;
        b_load       = 1'b1;
        mux_ula1     = 2'b01;
        mux_ula2     = 2'b11;
        ula          = 3'b001;
        ula_out_load = 1'b1;
        op_d         = opcode;
        case (opcode)
          OP_ADDI:                              state_d = ST_EXEC;
          OP_LUI:                               state_d = ST_WB_LUI;
          OP_LW, OP_LH, OP_LB, OP_SW, OP_SB,
          OP_SLLM:                              state_d = ST_ADDR;
          OP_BEQ, OP_BNE:                       state_d = ST_BRANCH;
          OP_NOP:                               state_d = ST_FETCH1;
          default:                              state_d = ST_EXC_OPC;
        endcase
      end
      ST_EXEC, ST_ADDR: begin
        mux_ula1     = 2'b00;
        mux_ula2     = 2'b01;
        ula          = 3'b001;
        ula_out_load = 1'b1;
        if (state_q == ST_EXEC) state_d = overflow ? ST_EXC_OVF : ST_WB_ALU;
        else state_d = (op_q == OP_SW || op_q == OP_SB) ? ST_STORE : ST_MEM1;
      end
      ST_WB_ALU: begin
        reg_wr  = 1'b1;
        state_d = ST_FETCH1;
      end
      ST_WB_LUI: begin
        reg_wr          = 1'b1;
        mux_register_wd = 3'b010;
        state_d         = ST_FETCH1;
      end
      ST_MEM1: state_d = ST_MEM2;
      ST_MEM2: state_d = ST_MDR;
      ST_MDR: begin
        mdr_load = 1'b1;
        state_d  = (op_q == OP_SLLM) ? ST_SH_LD : ST_WB_MEM;
      end
      ST_WB_MEM: begin
        reg_wr          = 1'b1;
        mux_register_wd = 3'b001;
        load_size       = (op_q == OP_LH) ? 2'b01 : (op_q == OP_LB) ? 2'b10 : 2'b00;
        state_d         = ST_FETCH1;
      end
      ST_SH_LD: begin
        shift         = 3'b001;
        mux_shift_src = 1'b1;
        mux_shift_amt = 2'b01;
        state_d       = ST_SH_DO;
      end
      ST_SH_DO: begin
        shift         = 3'b010;
        mux_shift_amt = 2'b01;
        state_d       = ST_WB_SH;
      end
      ST_WB_SH: begin
        reg_wr          = 1'b1;
        mux_register_wd = 3'b011;
        state_d         = ST_FETCH1;
      end
      ST_STORE: begin
        memory_wr  = 1'b1;
        store_size = (op_q == OP_SB);
        state_d    = ST_FETCH1;
      end
      ST_BRANCH: begin
        ula      = 3'b010;
        mux_pc   = 2'b01;
        is_beq   = (op_q == OP_BEQ);
        is_bne   = (op_q == OP_BNE);
        pc_write = (op_q == OP_BEQ) ? zero_div : ~zero_div;
        state_d  = ST_FETCH1;
      end
      ST_EXC_OPC, ST_EXC_OVF: begin
        epc_load = 1'b1;
        mux_ula1 = 2'b01;
        mux_ula2 = 2'b10;
        ula      = 3'b010;
        pc_write = 1'b1;
        mux_pc   = (state_q == ST_EXC_OPC) ? 2'b10 : 2'b11;
        state_d  = ST_FETCH1;
      end
      default: state_d = ST_RESET;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: each stimulus cycle queues the expected
// output word for the state the FSM should occupy; a monitor checks at negedge.
module tb_control_unit;

  typedef struct packed {
    logic [1:0] mux_a, mux_ula1, mux_ula2, mux_shift_amt, mux_pc, mux_register_wr, load_size;
    logic [2:0] mux_address, mux_register_wd, ula, shift;
    logic mux_b, mux_shift_src, mux_memory_wd, mux_high, mux_low, mux_extend, store_size;
    logic address_rg_load, epc_load, mdr_load, ir_load, high_load, low_load, a_load, b_load, ula_out_load;
    logic pc_write, memory_wr, reg_wr, is_beq, is_bne, mult_init, div_init;
  } out_t;

  typedef enum int {
    T_RESET, T_F1, T_F2, T_F3, T_DECODE, T_EXEC, T_WB_ALU, T_WB_LUI, T_ADDR,
    T_MEM1, T_MEM2, T_MDR, T_WB_MEM, T_SH_LD, T_SH_DO, T_WB_SH, T_STORE,
    T_BRANCH, T_EXC_OPC, T_EXC_OVF
  } tst_t;

  typedef struct {
    out_t v;
    tst_t st;
  } exp_t;

  logic clk = 1'b0;
  logic reset_in, overflow, zero_div;
  logic [5:0] opcode;
  logic [15:0] immediate;
  out_t act;

  exp_t sb_q[$];
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  control_unit dut (
    .clk(clk), .reset_in(reset_in), .opcode(opcode), .immediate(immediate),
    .overflow(overflow), .zero_div(zero_div),
    .mult_stop(1'b0), .div_stop(1'b0), .div_zero(1'b0),
    .mux_a(act.mux_a), .mux_ula1(act.mux_ula1), .mux_ula2(act.mux_ula2),
    .mux_shift_amt(act.mux_shift_amt), .mux_pc(act.mux_pc),
    .mux_register_wr(act.mux_register_wr), .load_size(act.load_size),
    .mux_address(act.mux_address), .mux_register_wd(act.mux_register_wd),
    .ula(act.ula), .shift(act.shift), .mux_b(act.mux_b),
    .mux_shift_src(act.mux_shift_src), .mux_memory_wd(act.mux_memory_wd),
    .mux_high(act.mux_high), .mux_low(act.mux_low), .mux_extend(act.mux_extend),
    .store_size(act.store_size), .address_rg_load(act.address_rg_load),
    .epc_load(act.epc_load), .mdr_load(act.mdr_load), .ir_load(act.ir_load),
    .high_load(act.high_load), .low_load(act.low_load), .a_load(act.a_load),
    .b_load(act.b_load), .ula_out_load(act.ula_out_load),
    .pc_write(act.pc_write), .memory_wr(act.memory_wr), .reg_wr(act.reg_wr),
    .is_beq(act.is_beq), .is_bne(act.is_bne), .mult_init(act.mult_init),
    .div_init(act.div_init)
  );

  // Expected output word per state, written straight from the control table.
  function automatic out_t expect_vec(input tst_t st, input logic [5:0] op, input logic zd);
    out_t o;
    o = '0;
    case (st)
      T_F1, T_F2, T_F3: begin
        o.mux_address = 3'b001; o.mux_ula1 = 2'b01; o.mux_ula2 = 2'b10; o.ula = 3'b001;
        if (st == T_F3) begin o.ir_load = 1'b1; o.pc_write = 1'b1; end
      end
      T_DECODE: begin
        o.a_load = 1'b1; o.b_load = 1'b1; o.mux_ula1 = 2'b01; o.mux_ula2 = 2'b11;
        o.ula = 3'b001; o.ula_out_load = 1'b1;
      end
      T_EXEC, T_ADDR: begin
        o.mux_ula2 = 2'b01; o.ula = 3'b001; o.ula_out_load = 1'b1;
      end
      T_WB_ALU: o.reg_wr = 1'b1;
      T_WB_LUI: begin o.reg_wr = 1'b1; o.mux_register_wd = 3'b010; end
      T_MDR:    o.mdr_load = 1'b1;
      T_WB_MEM: begin
        o.reg_wr = 1'b1; o.mux_register_wd = 3'b001;
        o.load_size = (op == 6'b100001) ? 2'b01 : (op == 6'b100000) ? 2'b10 : 2'b00;
      end
      T_SH_LD:  begin o.shift = 3'b001; o.mux_shift_src = 1'b1; o.mux_shift_amt = 2'b01; end
      T_SH_DO:  begin o.shift = 3'b010; o.mux_shift_amt = 2'b01; end
      T_WB_SH:  begin o.reg_wr = 1'b1; o.mux_register_wd = 3'b011; end
      T_STORE:  begin o.memory_wr = 1'b1; o.store_size = (op == 6'b101000); end
      T_BRANCH: begin
        o.ula = 3'b010; o.mux_pc = 2'b01;
        o.is_beq = (op == 6'b000100); o.is_bne = (op == 6'b000101);
        o.pc_write = o.is_beq ? zd : ~zd;
      end
      T_EXC_OPC, T_EXC_OVF: begin
        o.epc_load = 1'b1; o.mux_ula1 = 2'b01; o.mux_ula2 = 2'b10; o.ula = 3'b010;
        o.pc_write = 1'b1; o.mux_pc = (st == T_EXC_OPC) ? 2'b10 : 2'b11;
      end
      default: o = '0;
    endcase
    return o;
  endfunction

  // One clock: st is the state entered at this edge; inputs applied now steer
  // this state's outputs and the next transition.
  task automatic cyc(input tst_t st, input logic [5:0] op, input logic ovf,
                     input logic zd, input logic rst);
    exp_t e;
    @(posedge clk);
    #1;
    opcode    = op;
    overflow  = ovf;
    zero_div  = zd;
    reset_in  = rst;
    immediate = 16'hA5C3 ^ {10'd0, op};
    e.v  = expect_vec(st, op, zd);
    e.st = st;
    sb_q.push_back(e);
  endtask

  task automatic fetch(input logic [5:0] op);
    cyc(T_F1, op, 1'b0, 1'b0, 1'b0);
    cyc(T_F2, op, 1'b0, 1'b0, 1'b0);
    cyc(T_F3, op, 1'b0, 1'b0, 1'b0);
    cyc(T_DECODE, op, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic mem_read(input logic [5:0] op);
    fetch(op);
    cyc(T_ADDR, op, 1'b0, 1'b0, 1'b0);
    cyc(T_MEM1, op, 1'b0, 1'b0, 1'b0);
    cyc(T_MEM2, op, 1'b0, 1'b0, 1'b0);
    cyc(T_MDR, op, 1'b0, 1'b0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      n_checks++;
      if (act !== e.v) begin
        n_fail++;
        $display("FAIL state_%s outputs: got %h expected %h", e.st.name(), act, e.v);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    logic [5:0] ops[3];
    logic [5:0] bops[2];
    reset_in  = 1'b1;
    opcode    = '0;
    overflow  = 1'b0;
    zero_div  = 1'b0;
    immediate = '0;

    cyc(T_RESET, 6'b000000, 1'b0, 1'b0, 1'b1);
    cyc(T_RESET, 6'b000000, 1'b0, 1'b0, 1'b0);

    fetch(6'b001000);
    cyc(T_EXEC, 6'b001000, 1'b0, 1'b0, 1'b0);
    cyc(T_WB_ALU, 6'b001000, 1'b0, 1'b0, 1'b0);

    fetch(6'b001000);
    cyc(T_EXEC, 6'b001000, 1'b1, 1'b0, 1'b0);
    cyc(T_EXC_OVF, 6'b001000, 1'b0, 1'b0, 1'b0);

    ops[0] = 6'b100000; ops[1] = 6'b100001; ops[2] = 6'b100011;
    for (int i = 0; i < 3; i++) begin
      mem_read(ops[i]);
      cyc(T_WB_MEM, ops[i], 1'b0, 1'b0, 1'b0);
    end

    bops[0] = 6'b101000; bops[1] = 6'b101011;
    for (int i = 0; i < 2; i++) begin
      fetch(bops[i]);
      cyc(T_ADDR, bops[i], 1'b0, 1'b0, 1'b0);
      cyc(T_STORE, bops[i], 1'b0, 1'b0, 1'b0);
    end

    mem_read(6'b001001);
    cyc(T_SH_LD, 6'b001001, 1'b0, 1'b0, 1'b0);
    cyc(T_SH_DO, 6'b001001, 1'b0, 1'b0, 1'b0);
    cyc(T_WB_SH, 6'b001001, 1'b0, 1'b0, 1'b0);

    bops[0] = 6'b000100; bops[1] = 6'b000101;
    for (int i = 0; i < 2; i++) begin
      for (int z = 0; z < 2; z++) begin
        fetch(bops[i]);
        cyc(T_BRANCH, bops[i], 1'b0, z[0], 1'b0);
      end
    end

    fetch(6'b001111);
    cyc(T_WB_LUI, 6'b001111, 1'b0, 1'b0, 1'b0);

    fetch(6'b111111);
    cyc(T_EXC_OPC, 6'b111111, 1'b0, 1'b0, 1'b0);
    fetch(6'b000010);
    cyc(T_EXC_OPC, 6'b000010, 1'b0, 1'b0, 1'b0);

    fetch(6'b000000);

    fetch(6'b100011);
    cyc(T_ADDR, 6'b100011, 1'b0, 1'b0, 1'b0);
    cyc(T_MEM1, 6'b100011, 1'b0, 1'b0, 1'b0);
    cyc(T_MEM2, 6'b100011, 1'b0, 1'b0, 1'b1);
    cyc(T_RESET, 6'b100011, 1'b0, 1'b0, 1'b1);
    cyc(T_RESET, 6'b100011, 1'b0, 1'b0, 1'b0);

    fetch(6'b000100);
    cyc(T_BRANCH, 6'b000100, 1'b0, 1'b1, 1'b1);
    cyc(T_RESET, 6'b000100, 1'b0, 1'b0, 1'b0);
    cyc(T_F1, 6'b000000, 1'b0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
